// File: rtl/fir_mac_pipe.sv
// Three-stage signed multiply-accumulate pipeline with self-sequenced tap grouping and backpressure.
// Define FIR_MAC_SAT_EN to saturate the output and expose sat_flag; otherwise the output wraps.
module fir_mac_pipe #(
    parameter int pDATA_WIDTH = 32,
    parameter int pCOEF_WIDTH = 32,
    parameter int pACC_WIDTH  = 48,
    parameter int pOUT_SHIFT  = 0,
    parameter int pTAP_MAX    = 32,
    localparam int CNT_W      = $clog2(pTAP_MAX + 1)
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic                          cal_clr,
    input  logic [CNT_W-1:0]              cfg_tap_num,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [pDATA_WIDTH-1:0] in_data,
    input  logic signed [pCOEF_WIDTH-1:0] in_tap,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [pDATA_WIDTH-1:0]        out_y,
    output logic                          busy
`ifdef FIR_MAC_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    logic                   stall;
    logic                   accept;

    logic [CNT_W-1:0]       tap_cnt;
    logic [CNT_W-1:0]       tap_n;
    logic [CNT_W-1:0]       cfg_n;
    logic [CNT_W-1:0]       grp_n;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   is_first;
    logic                   is_last;

    logic                          s1_v;
    logic signed [pDATA_WIDTH-1:0] s1_x;
    logic signed [pCOEF_WIDTH-1:0] s1_h;
    logic                          s1_first;
    logic                          s1_last;

    logic signed [pACC_WIDTH-1:0]  prod_acc;
    logic                          s2_v;
    logic signed [pACC_WIDTH-1:0]  s2_p;
    logic                          s2_first;
    logic                          s2_last;

    logic signed [pACC_WIDTH-1:0]  acc;
    logic signed [pACC_WIDTH-1:0]  sum;
    logic [pDATA_WIDTH-1:0]        y_fmt;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign busy     = s1_v | s2_v | out_valid | (tap_cnt != '0);

    // The effective group length is only taken from cfg_tap_num when a group opens.
    always_comb begin
        cfg_n = cfg_tap_num;
        if (cfg_tap_num == '0) begin
            cfg_n = CNT_W'(1);
        end else if (cfg_tap_num > CNT_W'(pTAP_MAX)) begin
            cfg_n = CNT_W'(pTAP_MAX);
        end
    end

    assign is_first = (tap_cnt == '0);
    assign grp_n    = is_first ? cfg_n : tap_n;
    assign cnt_inc  = tap_cnt + CNT_W'(1);
    assign is_last  = (cnt_inc == grp_n);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            tap_cnt <= '0;
            tap_n   <= '0;
        end else if (cal_clr) begin
            tap_cnt <= '0;
        end else if (accept) begin
            if (is_first) begin
                tap_n <= cfg_n;
            end
            tap_cnt <= is_last ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            s1_v     <= 1'b0;
            s1_x     <= '0;
            s1_h     <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (cal_clr) begin
            s1_v <= 1'b0;
        end else if (!stall) begin
            s1_v <= accept;
            if (accept) begin
                s1_x     <= in_data;
                s1_h     <= in_tap;
                s1_first <= is_first;
                s1_last  <= is_last;
            end
        end
    end

    // Low pACC_WIDTH bits of the full product; sign-extends when the accumulator is wider.
    assign prod_acc = pACC_WIDTH'(s1_x) * pACC_WIDTH'(s1_h);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            s2_v     <= 1'b0;
            s2_p     <= '0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else if (cal_clr) begin
            s2_v <= 1'b0;
        end else if (!stall) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_p     <= prod_acc;
                s2_first <= s1_first;
                s2_last  <= s1_last;
            end
        end
    end

    assign sum = s2_first ? s2_p : acc + s2_p;

`ifdef FIR_MAC_SAT_EN
    logic signed [pACC_WIDTH-1:0]  shifted;
    logic [pACC_WIDTH-pDATA_WIDTH:0] upper;
    logic                          clip;

    assign shifted = sum >>> pOUT_SHIFT;
    assign upper   = shifted[pACC_WIDTH-1:pDATA_WIDTH-1];
    // Fits when every bit from the output sign bit upward agrees.
    assign clip    = ~((&upper) | ~(|upper));
    always_comb begin
        y_fmt = shifted[pDATA_WIDTH-1:0];
        if (clip) begin
            y_fmt = shifted[pACC_WIDTH-1] ? {1'b1, {(pDATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(pDATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign y_fmt = pDATA_WIDTH'(sum >>> pOUT_SHIFT);
`endif

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
`ifdef FIR_MAC_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else if (cal_clr) begin
            acc       <= '0;
            out_valid <= 1'b0;
`ifdef FIR_MAC_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else if (!stall) begin
            if (s2_v) begin
                acc <= sum;
            end
            if (s2_v && s2_last) begin
                out_valid <= 1'b1;
                out_y     <= y_fmt;
`ifdef FIR_MAC_SAT_EN
                sat_flag  <= clip;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_pipe.sv
// Bench for fir_mac_pipe: directed steps plus randomized traffic against a group-sum reference model.
// Honours FIR_MAC_SAT_EN to pick saturating or wrapping expectations.
module tb_fir_mac_pipe;
    localparam int DW   = 32;
    localparam int CWD  = 32;
    localparam int AW   = 48;
    localparam int SH   = 0;
    localparam int TMAX = 32;
    localparam int NW   = $clog2(TMAX + 1);
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic           axis_clk = 1'b0;
    logic           axis_rst_n;
    logic           cal_clr;
    logic [NW-1:0]  cfg_tap_num;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [CWD-1:0] in_tap;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_y;
    logic           busy;
`ifdef FIR_MAC_SAT_EN
    logic           sat_flag;
`endif

    fir_mac_pipe #(
        .pDATA_WIDTH(DW), .pCOEF_WIDTH(CWD), .pACC_WIDTH(AW),
        .pOUT_SHIFT(SH), .pTAP_MAX(TMAX)
    ) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cal_clr(cal_clr),
        .cfg_tap_num(cfg_tap_num), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tap(in_tap), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .busy(busy)
`ifdef FIR_MAC_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [31:0] y;
        logic        sat;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     errors = 0;
    int     checks = 0;
    int     m_cnt  = 0;
    int     m_n    = 0;
    longint m_sum  = 0;
    bit     bp     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference: a group is a run of n accepted pairs, n fixed at the first pair.
    function automatic void model_accept(input int x, input int h, input logic [NW-1:0] cfg);
        int     c;
        longint s48;
        longint sh;
        exp_t   e;
        if (m_cnt == 0) begin
            c = int'(cfg);
            m_n = (c == 0) ? 1 : ((c > TMAX) ? TMAX : c);
            m_sum = 0;
        end
        m_sum = m_sum + longint'(x) * longint'(h);
        m_cnt++;
        if (m_cnt == m_n) begin
            s48 = (m_sum <<< (64 - AW)) >>> (64 - AW);
            sh  = s48 >>> SH;
            e.sat = 1'b0;
            e.y   = sh[31:0];
`ifdef FIR_MAC_SAT_EN
            if (sh > MAXV) begin
                e.y = MAXV[31:0];
                e.sat = 1'b1;
            end else if (sh < MINV) begin
                e.y = MINV[31:0];
                e.sat = 1'b1;
            end
`endif
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endfunction

    always @(negedge axis_clk) begin
        if (axis_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_y, 32'hxxxx_xxxx);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream_y", out_y, mon_e.y);
`ifdef FIR_MAC_SAT_EN
                chk("stream_sat", {31'd0, sat_flag}, {31'd0, mon_e.sat});
`endif
            end
        end
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
        if (bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int x, input int h);
        in_data  = x;
        in_tap   = h;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge axis_clk);
            if (in_ready) begin
                model_accept(x, h, cfg_tap_num);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] y);
        for (int i = 0; i < 12; i++) begin
            @(negedge axis_clk);
            if (out_valid) break;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, out_y, y);
        tick();
    endtask

    task automatic drain();
        bp = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge axis_clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_queue", exp_q.size(), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_rst_n  = 1'b0;
        cal_clr     = 1'b0;
        cfg_tap_num = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_tap      = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Three-tap group and its latency.
        cfg_tap_num = 3;
        send(1, 4);
        send(2, 5);
        send(3, 6);
        @(negedge axis_clk);
        chk("t1_lat1", {31'd0, out_valid}, 32'd0);
        @(negedge axis_clk);
        chk("t1_lat2", {31'd0, out_valid}, 32'd0);
        @(negedge axis_clk);
        chk("t1_lat3", {31'd0, out_valid}, 32'd1);
        chk("t1_y", out_y, 32'd32);
        @(negedge axis_clk);
        chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        tick();

        // Single-tap groups, negative result and back-to-back outputs.
        cfg_tap_num = 1;
        send(-2, 3);
        expect_out("t2_neg", 32'hFFFF_FFFA);
        send(5, 5);
        send(7, -1);
        @(negedge axis_clk);
        @(negedge axis_clk);
        chk("t2_b2b_v0", {31'd0, out_valid}, 32'd1);
        chk("t2_b2b_y0", out_y, 32'd25);
        @(negedge axis_clk);
        chk("t2_b2b_v1", {31'd0, out_valid}, 32'd1);
        chk("t2_b2b_y1", out_y, 32'(-7));
        tick();
        drain();

        // Backpressure: first result must hold and nothing may be lost.
        cfg_tap_num = 2;
        out_ready = 1'b0;
        send(2, 3);
        send(1, 4);
        send(4, 5);
        send(0, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge axis_clk);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_y", out_y, 32'd10);
            chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        end
        tick();
        out_ready = 1'b1;
        drain();

        // Overflow of the output width.
        cfg_tap_num = 1;
        send(32'h7FFF_FFFF, 2);
`ifdef FIR_MAC_SAT_EN
        expect_out("t4_big", 32'h7FFF_FFFF);
`else
        expect_out("t4_big", 32'hFFFF_FFFE);
`endif
        drain();

        // Flush discards a partial group.
        cfg_tap_num = 4;
        send(9, 9);
        send(9, 9);
        tick();
        @(negedge axis_clk);
        chk("t5_busy_partial", {31'd0, busy}, 32'd1);
        tick();
        cal_clr = 1'b1;
        m_cnt = 0;
        tick();
        cal_clr = 1'b0;
        @(negedge axis_clk);
        chk("t5_clr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_clr_busy", {31'd0, busy}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) send(1, 1);
        expect_out("t5_y", 32'd4);
        drain();

        // cfg_tap_num of zero and mid-group changes.
        cfg_tap_num = 0;
        send(3, 3);
        expect_out("t6_zero", 32'd9);
        cfg_tap_num = 3;
        send(1, 1);
        cfg_tap_num = 2;
        send(2, 2);
        repeat (4) @(negedge axis_clk);
        chk("t6_no_early", {31'd0, out_valid}, 32'd0);
        tick();
        send(3, 3);
        expect_out("t6_mid", 32'd14);
        drain();

        // Randomized traffic with gaps, backpressure and changing group lengths.
        bp = 1;
        for (int i = 0; i < 300; i++) begin
            cfg_tap_num = NW'($urandom_range(0, 40));
            send(int'($urandom), int'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        while (m_cnt != 0) send(int'($urandom), int'($urandom));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
